// File: rtl/ten_bit_subtractor_seq_pkg.sv
// rtl/ten_bit_subtractor_seq_pkg.sv - shared widths and FSM encoding for the sliced subtractor
package ten_bit_subtractor_seq_pkg;
  localparam int DATA_W  = 10;
  localparam int SLICE_W = 4;
  localparam int EXT_W   = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S0   = 3'd1,
    ST_S1   = 3'd2,
    ST_S2   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;
endpackage

// File: rtl/ten_bit_subtractor_seq_adder.sv
// rtl/ten_bit_subtractor_seq_adder.sv - 4-bit ripple slice adder with carry in/out
module FourBitAdder
  import ten_bit_subtractor_seq_pkg::*;
(
  input  logic               cin,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
endmodule

// File: rtl/ten_bit_subtractor_seq.sv
// rtl/ten_bit_subtractor_seq.sv - 10-bit signed subtractor, one 4-bit slice per cycle
// A - B is formed as A + ~B + 1 through a single time-shared slice adder.
module ten_bit_subtractor_seq
  import ten_bit_subtractor_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Diff,
  output logic              Overflow,
  output logic              busy,
  output logic              done
);
  localparam int TOP_LO = DATA_W - 2*SLICE_W;

  state_t               state, state_next;
  logic [DATA_W-1:0]    a_q, b_q;
  logic [EXT_W-1:0]     a_ext, b_ext;
  logic [2*SLICE_W-1:0] low_q;
  logic                 carry_q;
  logic [SLICE_W-1:0]   slice_a, slice_b, slice_sum;
  logic                 slice_cin, slice_cout;
  logic                 slice_msb_unused;

  assign a_ext = {{(EXT_W-DATA_W){a_q[DATA_W-1]}}, a_q};
  assign b_ext = {{(EXT_W-DATA_W){~b_q[DATA_W-1]}}, ~b_q};
  // Bit 11 of the extended result only duplicates bit 10.
  assign slice_msb_unused = slice_sum[SLICE_W-1];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    slice_a    = a_ext[0 +: SLICE_W];
    slice_b    = b_ext[0 +: SLICE_W];
    slice_cin  = 1'b1;
    case (state)
      ST_IDLE: if (start) state_next = ST_S0;
      ST_S0:   state_next = ST_S1;
      ST_S1: begin
        state_next = ST_S2;
        slice_a    = a_ext[SLICE_W +: SLICE_W];
        slice_b    = b_ext[SLICE_W +: SLICE_W];
        slice_cin  = carry_q;
      end
      ST_S2: begin
        state_next = ST_FIN;
        slice_a    = a_ext[2*SLICE_W +: SLICE_W];
        slice_b    = b_ext[2*SLICE_W +: SLICE_W];
        slice_cin  = carry_q;
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  FourBitAdder u_adder (
    .cin  (slice_cin),
    .a    (slice_a),
    .b    (slice_b),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      low_q    <= '0;
      carry_q  <= 1'b0;
      Diff     <= '0;
      Overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      done <= (state_next == ST_FIN);
      case (state)
        ST_IDLE: if (start) begin
          a_q <= A;
          b_q <= B;
        end
        ST_S0: begin
          low_q[0 +: SLICE_W] <= slice_sum;
          carry_q             <= slice_cout;
        end
        ST_S1: begin
          low_q[SLICE_W +: SLICE_W] <= slice_sum;
          carry_q                   <= slice_cout;
        end
        // Final carry-out is dropped; overflow is bit 10 vs bit 9 of the result.
        ST_S2: begin
          Diff     <= {slice_sum[TOP_LO-1:0], low_q};
          Overflow <= slice_sum[TOP_LO] ^ slice_sum[TOP_LO-1];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ten_bit_subtractor_seq.sv
// tb/tb_ten_bit_subtractor_seq.sv - self-checking bench for ten_bit_subtractor_seq
module tb_ten_bit_subtractor_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] A = '0;
  logic [9:0] B = '0;
  logic [9:0] Diff;
  logic       Overflow;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ten_bit_subtractor_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .Diff     (Diff),
    .Overflow (Overflow),
    .busy     (busy),
    .done     (done)
  );

  function automatic void ref_sub(input logic [9:0] a, input logic [9:0] b,
                                  output logic [9:0] d, output logic o);
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r  = sa - sb;
    d  = r[9:0];
    o  = (r > 511) || (r < -512);
  endfunction

  // Pulse start with a/b, scramble A/B afterwards, return edges until done and busy cycles seen.
  task automatic do_op(input logic [9:0] a, input logic [9:0] b, input bit release_reset,
                       output int lat, output int busy_cycles);
    @(posedge clk); #1;
    if (release_reset) reset = 1'b0;
    start = 1'b1; A = a; B = b;
    lat = 0; busy_cycles = 0;
    do begin
      @(posedge clk); #1;
      if (lat == 0) begin
        start = 1'b0;
        A = 10'($urandom);
        B = 10'($urandom);
      end
      lat++;
      if (busy) busy_cycles++;
    end while (!done && lat < 12);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (Diff !== 10'h000) begin errors++; $display("FAIL reset_diff got=%h exp=000", Diff); end
    if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", Overflow); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc;
    do_op(10'd5, 10'd3, 1'b0, lat, bc);
    checks += 4;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
    if (Diff !== 10'h002) begin errors++; $display("FAIL basic_diff got=%h exp=002", Diff); end
    if (Overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b exp=0", Overflow); end
    @(posedge clk); #1;
    checks += 3;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    if (Diff !== 10'h002) begin errors++; $display("FAIL basic_diff_hold got=%h exp=002", Diff); end
  endtask

  task automatic test_directed();
    logic [9:0] ta [4] = '{10'h000, 10'h200, 10'h1FF, 10'h155};
    logic [9:0] tb [4] = '{10'h001, 10'h001, 10'h3FF, 10'h155};
    logic [9:0] td [4] = '{10'h3FF, 10'h1FF, 10'h200, 10'h000};
    logic       tov[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], 1'b0, lat, bc);
      checks += 3;
      if (lat !== 4) begin errors++; $display("FAIL directed%0d_latency got=%0d exp=4", i, lat); end
      if (Diff !== td[i]) begin errors++; $display("FAIL directed%0d_diff got=%h exp=%h", i, Diff, td[i]); end
      if (Overflow !== tov[i]) begin errors++; $display("FAIL directed%0d_ovf got=%b exp=%b", i, Overflow, tov[i]); end
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    @(posedge clk); #1;
    start = 1'b1; A = 10'd7; B = 10'd2;
    @(posedge clk); #1;              // S0
    start = 1'b0; A = 10'd0;
    if (done) dones++;
    @(posedge clk); #1;              // S1
    start = 1'b1; A = 10'd100; B = 10'd1;
    if (done) dones++;
    @(posedge clk); #1;              // S2
    start = 1'b0;
    if (done) dones++;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks += 3;
    if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    if (Diff !== 10'h005) begin errors++; $display("FAIL ignore_diff got=%h exp=005", Diff); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, dones = 0;
    do_op(10'h3F0, 10'h001, 1'b0, lat, bc);   // leave nonzero outputs behind
    @(posedge clk); #1;
    start = 1'b1; A = 10'd9; B = 10'd4;
    for (int i = 0; i < 3; i++) begin          // S0, S1, S2
      @(posedge clk); #1;
      start = 1'b0;
      if (done) dones++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    if (done) dones++;
    checks += 5;
    if (dones !== 0) begin errors++; $display("FAIL midreset_done got=%0d exp=0", dones); end
    if (Diff !== 10'h000) begin errors++; $display("FAIL midreset_diff got=%h exp=000", Diff); end
    if (Overflow !== 1'b0) begin errors++; $display("FAIL midreset_ovf got=%b exp=0", Overflow); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL midreset_done_now got=%b exp=0", done); end
    do_op(10'd9, 10'd4, 1'b1, lat, bc);
    checks += 3;
    if (lat !== 4) begin errors++; $display("FAIL postreset_latency got=%0d exp=4", lat); end
    if (Diff !== 10'h005) begin errors++; $display("FAIL postreset_diff got=%h exp=005", Diff); end
    if (Overflow !== 1'b0) begin errors++; $display("FAIL postreset_ovf got=%b exp=0", Overflow); end
  endtask

  task automatic test_back_to_back();
    int edges = 0, first = -1, second = -1, waited = 0;
    logic [9:0] ed; logic eo;
    ref_sub(10'h123, 10'h2F1, ed, eo);
    @(posedge clk); #1;
    start = 1'b1; A = 10'h123; B = 10'h2F1;
    while (second < 0 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (done) begin
        if (first < 0) first = edges;
        else second = edges;
      end
    end
    start = 1'b0;
    checks += 4;
    if (first !== 4) begin errors++; $display("FAIL b2b_first got=%0d exp=4", first); end
    if (second - first !== 5) begin errors++; $display("FAIL b2b_interval got=%0d exp=5", second - first); end
    if (Diff !== ed) begin errors++; $display("FAIL b2b_diff got=%h exp=%h", Diff, ed); end
    if (Overflow !== eo) begin errors++; $display("FAIL b2b_ovf got=%b exp=%b", Overflow, eo); end
    while (busy && waited < 10) begin @(posedge clk); #1; waited++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [9:0] a, b, ed;
    logic eo;
    for (int i = 0; i < 1000; i++) begin
      a = 10'($urandom);
      b = 10'($urandom);
      if (i < 8) begin a[9] = i[0]; b[9] = i[1]; end
      ref_sub(a, b, ed, eo);
      do_op(a, b, 1'b0, lat, bc);
      checks += 3;
      if (lat !== 4) begin errors++; $display("FAIL rand%0d_latency a=%h b=%h got=%0d exp=4", i, a, b, lat); end
      if (Diff !== ed) begin errors++; $display("FAIL rand%0d_diff a=%h b=%h got=%h exp=%h", i, a, b, Diff, ed); end
      if (Overflow !== eo) begin errors++; $display("FAIL rand%0d_ovf a=%h b=%h got=%b exp=%b", i, a, b, Overflow, eo); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
